branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

Sequences the branch prediction unit's lifetime per branch: records each prediction issued at fetch, matches it in order against execute-stage resolution, and issues one training update to the BPU per branch. On a misprediction it flushes the wrong path and redirects fetch. It sits between fetch/BPU and execute, and is the only block that drives BPU update inputs and pipeline branch flush.

## Interface
- `DEPTH`, 4: in-flight branch queue entries; a power of two, at least 2.
- `XLEN`, `N` (32): PC width, from `rtl/parameters.vh`.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `i_pred_valid` in 1: fetch issues a branch carrying a BPU prediction.
- `i_pred_pc` in XLEN: PC of that branch.
- `i_pred_taken` in 1: BPU `o_prediction`.
- `i_pred_target` in XLEN: BPU `o_predicted_pc`.
- `o_pred_ready` out 1: a push is accepted this cycle.
- `i_res_valid` in 1: execute has resolved the oldest in-flight branch.
- `i_res_taken` in 1: actual direction.
- `i_res_target` in XLEN: actual taken target (branch PC + offset).
- `o_upd_valid` out 1: one-cycle BPU training strobe.
- `o_upd_pc` out XLEN: branch PC to train.
- `o_upd_taken` out 1: actual outcome to train.
- `o_flush` out 1: one-cycle wrong-path flush.
- `o_redirect_pc` out XLEN: correct fetch PC, valid only while `o_flush` is high.

## Operation
- **Queue.** A circular FIFO of {pc, pred_taken, pred_target}.
  - Read and write pointers are log2(DEPTH)+1 bits; full and empty are decided by the MSB compare.
- **Push.** Occurs when `i_pred_valid && o_pred_ready`.
  - `o_pred_ready = !full && state==RUN`.
  - When the queue is full, a push is refused even if a pop happens in the same cycle.
- **Pop.** Occurs when `i_res_valid && !empty && state==RUN`. Execution resolves strictly in order.
- **Mispredict condition** (evaluated on the head entry): `pred_taken != res_taken`, or (`res_taken && pred_target != res_target`).
- **Redirect value.**
  - If `res_taken`, `o_redirect_pc = res_target`.
  - Otherwise `o_redirect_pc = head.pc + 4`, computed modulo 2^XLEN (wraps from 0xFFFFFFFC to 0).
- **Every pop** produces `o_upd_valid=1` with the head's pc and `res_taken`.
- **FSM states.**
  - RUN:
    - A pop that mispredicts sets `o_flush`.
    - It empties the whole queue, since younger entries are wrong-path.
    - It moves the FSM to FLUSH.
    - Any push in that same cycle is discarded.
  - FLUSH: lasts exactly one cycle. `o_pred_ready=0` and `i_res_valid` is ignored; the FSM then returns to RUN.
- **Boundary conditions.**
  - `i_res_valid` with an empty queue is ignored: no update and no flush.
  - Push and pop in the same cycle while not full and correctly predicted: occupancy is unchanged.
  - Push into an empty queue and pop of that same entry in the same cycle is impossible, because the head is read from registered state.

## Timing
- **Reset values.**
  - `o_upd_valid=0`, `o_upd_pc=0`, `o_upd_taken=0`.
  - `o_flush=0`, `o_redirect_pc=0`.
  - Queue empty, state RUN, and therefore `o_pred_ready=1`.
- **Reset mid-operation:** the next edge with `rst_n=0` empties the queue and clears all outputs. Pending flushes are dropped.
- **Latency.** `o_upd_*`, `o_flush` and `o_redirect_pc` are registered, asserted on the edge after the resolving `i_res_valid` cycle, and high for one cycle.
- **`o_pred_ready`** is combinational from registered state only, with no input-to-output path.
- **`o_redirect_pc`** holds its last value when `o_flush=0`; consumers must qualify it with `o_flush`.

## Configuration
- **`BPU_PERF_CNT_EN` defined:**
  - Adds outputs `o_branch_cnt` and `o_mispred_cnt`, each 32 bits.
  - `o_branch_cnt` increments on every pop; `o_mispred_cnt` increments on every mispredicting pop.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- **`BPU_PERF_CNT_EN` undefined:** the ports and counters do not exist.

## Structure
- **Shared package:** FSM state encoding (RUN=1'b0, FLUSH=1'b1), the queue-entry field widths, and the `PC_INC=4` constant.
- **Sub-module:** `branch_inflight_fifo`, a generic parameterised FIFO exposing `full`, `empty`, `head`, `push`, `pop` and `clear`.
- Mispredict compare, FSM and output registers live in the top module.

## Test plan
- **Reset:** hold `rst_n=0` for 2 edges. Expect all outputs 0 and `o_pred_ready=1`.
- **Correct not-taken:** push pc=0x10 with taken=0, then resolve taken=0. Expect `o_upd_valid=1`, `o_upd_pc=0x10`, `o_upd_taken=0` and `o_flush=0`, one cycle after resolution.
- **Direction mispredict:** push pc=0x14 (taken=0), then pc=0x18 and pc=0x1C. Resolve taken=1 with target=0x28. Expect:
  - `o_flush=1` and `o_redirect_pc=0x28`;
  - the queue empty and `o_pred_ready=0` for one cycle;
  - a later `i_res_valid` with no push produces no update.
- **Target mispredict:** push pc=0x20 (taken=1, target=0x40), then resolve taken=1 with target=0x44. Expect `o_flush=1` and `o_redirect_pc=0x44`.
- **Full queue:** push DEPTH entries. Expect `o_pred_ready=0`. A push together with a pop in the same cycle keeps occupancy at DEPTH-1 and the push is refused.
- **`BPU_PERF_CNT_EN`:** run 3 correct resolutions and 1 mispredict. Expect `o_branch_cnt=4` and `o_mispred_cnt=1`.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types for branch_resolve_ctrl: FSM encoding, queue entry, PC step.
// Exports XLEN, PC_INC, brc_state_e, bq_entry_t, ENTRY_W.
package branch_resolve_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } brc_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } bq_entry_t;

    localparam int ENTRY_W = $bits(bq_entry_t);

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Fetch/BPU/execute bundle for branch_resolve_ctrl.
// Ports: prediction push, resolution, BPU update, flush/redirect.
interface branch_resolve_ctrl_if;
    import branch_resolve_ctrl_pkg::*;

    logic            i_pred_valid;
    logic [XLEN-1:0] i_pred_pc;
    logic            i_pred_taken;
    logic [XLEN-1:0] i_pred_target;
    logic            o_pred_ready;

    logic            i_res_valid;
    logic            i_res_taken;
    logic [XLEN-1:0] i_res_target;

    logic            o_upd_valid;
    logic [XLEN-1:0] o_upd_pc;
    logic            o_upd_taken;
    logic            o_flush;
    logic [XLEN-1:0] o_redirect_pc;

    modport slave (
        input  i_pred_valid, i_pred_pc, i_pred_taken, i_pred_target,
        output o_pred_ready,
        input  i_res_valid, i_res_taken, i_res_target,
        output o_upd_valid, o_upd_pc, o_upd_taken,
        output o_flush, o_redirect_pc
    );

    modport master (
        output i_pred_valid, i_pred_pc, i_pred_taken, i_pred_target,
        input  o_pred_ready,
        output i_res_valid, i_res_taken, i_res_target,
        input  o_upd_valid, o_upd_pc, o_upd_taken,
        input  o_flush, o_redirect_pc
    );

endinterface

// File: rtl/branch_inflight_fifo.sv
// Generic circular FIFO with extra-MSB pointers and a whole-queue clear.
// Ports: clk, rst_n, i_push/i_pop/i_clear, i_data, o_full, o_empty, o_head.
module branch_inflight_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_head  = r_mem[r_rptr[AW-1:0]];

    assign w_wr = i_push && !o_full && !i_clear;
    assign w_rd = i_pop && !o_empty && !i_clear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// In-order branch prediction tracking, BPU training and mispredict flush.
// Ports: clk, rst_n, bus (slave); BPU_PERF_CNT_EN adds o_branch_cnt/o_mispred_cnt.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef BPU_PERF_CNT_EN
    output logic [31:0]            o_branch_cnt,
    output logic [31:0]            o_mispred_cnt,
`endif
    branch_resolve_ctrl_if.slave   bus
);

    brc_state_e      r_state;
    brc_state_e      w_state_nxt;

    logic            w_full;
    logic            w_empty;
    logic [ENTRY_W-1:0] w_head_raw;
    bq_entry_t       w_head;
    bq_entry_t       w_new;

    logic            w_pop;
    logic            w_push;
    logic            w_mis;
    logic            w_kill;
    logic [XLEN-1:0] w_redirect;

    logic            r_upd_valid;
    logic [XLEN-1:0] r_upd_pc;
    logic            r_upd_taken;
    logic            r_flush;
    logic [XLEN-1:0] r_redirect_pc;

    assign w_head = bq_entry_t'(w_head_raw);
    assign w_new  = '{pc:          bus.i_pred_pc,
                      pred_taken:  bus.i_pred_taken,
                      pred_target: bus.i_pred_target};

    assign bus.o_pred_ready = !w_full && (r_state == RUN);

    assign w_pop = bus.i_res_valid && !w_empty && (r_state == RUN);

    assign w_mis = (w_head.pred_taken != bus.i_res_taken) ||
                   (bus.i_res_taken &&
                    (w_head.pred_target != bus.i_res_target));

    assign w_kill = w_pop && w_mis;

    // Younger entries behind a mispredict are wrong-path; drop the push too.
    assign w_push = bus.i_pred_valid && bus.o_pred_ready && !w_kill;

    assign w_redirect = bus.i_res_taken ? bus.i_res_target
                                        : w_head.pc + PC_INC;

    branch_inflight_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_kill),
        .i_data  (w_new),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head_raw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN:     if (w_kill) w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_upd_valid   <= 1'b0;
            r_upd_pc      <= '0;
            r_upd_taken   <= 1'b0;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_upd_valid <= w_pop;
            r_flush     <= w_kill;
            if (w_pop) begin
                r_upd_pc    <= w_head.pc;
                r_upd_taken <= bus.i_res_taken;
            end
            if (w_kill) r_redirect_pc <= w_redirect;
        end
    end

    assign bus.o_upd_valid   = r_upd_valid;
    assign bus.o_upd_pc      = r_upd_pc;
    assign bus.o_upd_taken   = r_upd_taken;
    assign bus.o_flush       = r_flush;
    assign bus.o_redirect_pc = r_redirect_pc;

`ifdef BPU_PERF_CNT_EN
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_pop && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_kill && (r_mispred_cnt != '1))
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign o_branch_cnt  = r_branch_cnt;
    assign o_mispred_cnt = r_mispred_cnt;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl (DEPTH=4).
// Covers reset, correct/mispredicted resolution, wrap, full queue, counters.
module tb_branch_resolve_ctrl;
    import branch_resolve_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

`ifdef BPU_PERF_CNT_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;
`endif

    branch_resolve_ctrl_if bus ();

    branch_resolve_ctrl #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef BPU_PERF_CNT_EN
        .o_branch_cnt  (branch_cnt),
        .o_mispred_cnt (mispred_cnt),
`endif
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_pred_valid = 1'b0;
        bus.i_res_valid  = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt);
        bus.i_pred_valid  = 1'b1;
        bus.i_pred_pc     = pc;
        bus.i_pred_taken  = tk;
        bus.i_pred_target = tgt;
        step();
        bus.i_pred_valid  = 1'b0;
    endtask

    task automatic resolve(input logic tk, input logic [31:0] tgt);
        bus.i_res_valid  = 1'b1;
        bus.i_res_taken  = tk;
        bus.i_res_target = tgt;
        step();
        bus.i_res_valid  = 1'b0;
    endtask

    initial begin
        bus.i_pred_valid  = 1'b0;
        bus.i_pred_pc     = '0;
        bus.i_pred_taken  = 1'b0;
        bus.i_pred_target = '0;
        bus.i_res_valid   = 1'b0;
        bus.i_res_taken   = 1'b0;
        bus.i_res_target  = '0;

        rst_n = 1'b0;
        step();
        step();
        chk("rst_upd_valid", 32'(bus.o_upd_valid), 32'd0);
        chk("rst_upd_pc", bus.o_upd_pc, 32'd0);
        chk("rst_upd_taken", 32'(bus.o_upd_taken), 32'd0);
        chk("rst_flush", 32'(bus.o_flush), 32'd0);
        chk("rst_redirect", bus.o_redirect_pc, 32'd0);
        chk("rst_ready", 32'(bus.o_pred_ready), 32'd1);
        rst_n = 1'b1;

        // correct not-taken
        push(32'h10, 1'b0, 32'h50);
        resolve(1'b0, 32'h50);
        chk("nt_upd_valid", 32'(bus.o_upd_valid), 32'd1);
        chk("nt_upd_pc", bus.o_upd_pc, 32'h10);
        chk("nt_upd_taken", 32'(bus.o_upd_taken), 32'd0);
        chk("nt_flush", 32'(bus.o_flush), 32'd0);
        step();
        chk("nt_upd_pulse", 32'(bus.o_upd_valid), 32'd0);

        // direction mispredict with younger wrong-path entries
        push(32'h14, 1'b0, 32'h0);
        push(32'h18, 1'b0, 32'h0);
        push(32'h1C, 1'b0, 32'h0);
        bus.i_pred_valid  = 1'b1;
        bus.i_pred_pc     = 32'h20;
        bus.i_pred_taken  = 1'b0;
        resolve(1'b1, 32'h28);
        bus.i_pred_valid  = 1'b0;
        chk("dm_flush", 32'(bus.o_flush), 32'd1);
        chk("dm_redirect", bus.o_redirect_pc, 32'h28);
        chk("dm_upd_pc", bus.o_upd_pc, 32'h14);
        chk("dm_upd_taken", 32'(bus.o_upd_taken), 32'd1);
        chk("dm_ready_flush", 32'(bus.o_pred_ready), 32'd0);
        bus.i_res_valid = 1'b1;
        step();
        chk("dm_flush_pulse", 32'(bus.o_flush), 32'd0);
        chk("dm_flush_ignores_res", 32'(bus.o_upd_valid), 32'd0);
        chk("dm_ready_back", 32'(bus.o_pred_ready), 32'd1);
        chk("dm_redirect_hold", bus.o_redirect_pc, 32'h28);
        step();
        chk("dm_empty_no_upd", 32'(bus.o_upd_valid), 32'd0);
        chk("dm_empty_no_flush", 32'(bus.o_flush), 32'd0);
        idle();

        // not-taken redirect wraps at the top of the address space
        push(32'hFFFF_FFFC, 1'b1, 32'h100);
        resolve(1'b0, 32'h0);
        chk("wrap_flush", 32'(bus.o_flush), 32'd1);
        chk("wrap_redirect", bus.o_redirect_pc, 32'h0);
        step();

        // target mispredict
        push(32'h20, 1'b1, 32'h40);
        resolve(1'b1, 32'h44);
        chk("tm_flush", 32'(bus.o_flush), 32'd1);
        chk("tm_redirect", bus.o_redirect_pc, 32'h44);
        step();

        // correct taken: trains, no flush
        push(32'h30, 1'b1, 32'h60);
        resolve(1'b1, 32'h60);
        chk("ct_upd_valid", 32'(bus.o_upd_valid), 32'd1);
        chk("ct_upd_taken", 32'(bus.o_upd_taken), 32'd1);
        chk("ct_flush", 32'(bus.o_flush), 32'd0);

        // full queue
        for (int i = 0; i < 4; i++) push(32'h100 + 32'(i * 4), 1'b0, 32'h0);
        chk("full_ready", 32'(bus.o_pred_ready), 32'd0);
        bus.i_pred_valid = 1'b1;
        bus.i_pred_pc    = 32'h200;
        bus.i_pred_taken = 1'b0;
        resolve(1'b0, 32'h0);
        bus.i_pred_valid = 1'b0;
        chk("full_pop_pc", bus.o_upd_pc, 32'h100);
        chk("full_ready_after", 32'(bus.o_pred_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            resolve(1'b0, 32'h0);
            chk("full_drain_pc", bus.o_upd_pc, 32'h100 + 32'(i * 4));
        end
        resolve(1'b0, 32'h0);
        chk("full_push_refused", 32'(bus.o_upd_valid), 32'd0);

        // push and pop together, not full: occupancy stays at one
        push(32'h300, 1'b0, 32'h0);
        bus.i_pred_valid = 1'b1;
        bus.i_pred_pc    = 32'h304;
        resolve(1'b0, 32'h0);
        bus.i_pred_valid = 1'b0;
        chk("pp_pop_pc", bus.o_upd_pc, 32'h300);
        resolve(1'b0, 32'h0);
        chk("pp_second_pc", bus.o_upd_pc, 32'h304);
        resolve(1'b0, 32'h0);
        chk("pp_now_empty", 32'(bus.o_upd_valid), 32'd0);

        // reset mid-operation drops queue and pending flush
        push(32'h400, 1'b0, 32'h0);
        push(32'h404, 1'b0, 32'h0);
        rst_n = 1'b0;
        resolve(1'b1, 32'h500);
        rst_n = 1'b1;
        chk("mr_flush", 32'(bus.o_flush), 32'd0);
        chk("mr_upd_valid", 32'(bus.o_upd_valid), 32'd0);
        chk("mr_redirect", bus.o_redirect_pc, 32'd0);
        chk("mr_ready", 32'(bus.o_pred_ready), 32'd1);
        resolve(1'b0, 32'h0);
        chk("mr_queue_empty", 32'(bus.o_upd_valid), 32'd0);

`ifdef BPU_PERF_CNT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("pc_rst_branch", branch_cnt, 32'd0);
        for (int i = 0; i < 3; i++) begin
            push(32'h600 + 32'(i * 4), 1'b0, 32'h0);
            resolve(1'b0, 32'h0);
        end
        push(32'h700, 1'b0, 32'h0);
        resolve(1'b1, 32'h800);
        step();
        chk("pc_branch", branch_cnt, 32'd4);
        chk("pc_mispred", mispred_cnt, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
